// File: rtl/matvec_tile_engine.sv
// Tiled MxK matrix-vector engine: LANES-wide MAC row, BRAM fetch and result streaming.
// Optional MATVEC_SATURATE_EN clamps each accumulate and adds a sticky sat_flag output.
module matvec_tile_engine #(
    parameter int DATA_W    = 16,
    parameter int ACC_W     = 32,
    parameter int LANES     = 4,
    parameter int M_MAX     = 64,
    parameter int K_MAX     = 64,
    parameter int MEM_DEPTH = 256,
    localparam int AW = $clog2(MEM_DEPTH),
    localparam int MW = $clog2(M_MAX + 1),
    localparam int KW = $clog2(K_MAX + 1),
    localparam int RW = $clog2(M_MAX)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [MW-1:0]           m_rows,
    input  logic [KW-1:0]           k_cols,
    output logic [AW-1:0]           weight_bram_addr,
    output logic                    weight_bram_en,
    input  logic [LANES*DATA_W-1:0] weight_bram_dout,
    output logic [AW-1:0]           input_bram_addr,
    output logic                    input_bram_en,
    input  logic [DATA_W-1:0]       input_bram_dout,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
`ifdef MATVEC_SATURATE_EN
    output logic                    sat_flag,
`endif
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [ACC_W-1:0]        res_data,
    output logic [RW-1:0]           res_row
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_FETCH,
        S_DRAIN,
        S_OUT,
        S_FIN
    } state_t;

    state_t          state_q, state_d;
    logic [MW-1:0]   mcfg_q, mcfg_d;
    logic [KW-1:0]   kcfg_q, kcfg_d;
    logic [MW-1:0]   tiles_q, tiles_d;
    logic [MW-1:0]   tile_q, tile_d;
    logic [KW-1:0]   k_q, k_d;
    logic [AW-1:0]   base_q, base_d;
    logic [MW-1:0]   rbase_q, rbase_d;
    logic [LW-1:0]   lane_q, lane_d;
    logic            err_q, err_d;
    logic [AW-1:0]   waddr_q, iaddr_q;
    logic            issue_q, first_q;
    logic [LANES*ACC_W-1:0] acc_flat;
    logic [LANES-1:0]       ovf_vec;

    logic [31:0] m_ext, k_ext, t_ext, tk_ext, next_row;
    logic        cfg_bad, last_lane, fetch, out_st;

    assign fetch  = (state_q == S_FETCH);
    assign out_st = (state_q == S_OUT);

    // Tile count and BRAM footprint are derived from the latched config.
    assign m_ext   = 32'(mcfg_q);
    assign k_ext   = 32'(kcfg_q);
    assign t_ext   = (m_ext + 32'(LANES - 1)) / 32'(LANES);
    assign tk_ext  = t_ext * k_ext;
    assign cfg_bad = (m_ext == 32'd0) || (k_ext == 32'd0) ||
                     (m_ext > 32'(M_MAX)) || (k_ext > 32'(K_MAX)) ||
                     (tk_ext > 32'(MEM_DEPTH));

    assign next_row  = 32'(rbase_q) + 32'(lane_q) + 32'd1;
    assign last_lane = (lane_q == LW'(LANES - 1)) || (next_row >= m_ext);

`ifdef MATVEC_SATURATE_EN
    logic sat_q, sat_d;
`endif

    always_comb begin
        state_d = state_q;
        mcfg_d  = mcfg_q;
        kcfg_d  = kcfg_q;
        tiles_d = tiles_q;
        tile_d  = tile_q;
        k_d     = k_q;
        base_d  = base_q;
        rbase_d = rbase_q;
        lane_d  = lane_q;
        err_d   = err_q;
`ifdef MATVEC_SATURATE_EN
        sat_d   = sat_q | (issue_q & (|ovf_vec));
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcfg_d  = m_rows;
                    kcfg_d  = k_cols;
                    err_d   = 1'b0;
`ifdef MATVEC_SATURATE_EN
                    sat_d   = 1'b0;
`endif
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (cfg_bad) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    tiles_d = MW'(t_ext);
                    tile_d  = '0;
                    k_d     = '0;
                    base_d  = '0;
                    rbase_d = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                k_d = k_q + 1'b1;
                if (k_q == kcfg_q - 1'b1) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                lane_d  = '0;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (res_ready) begin
                    if (!last_lane) begin
                        lane_d = lane_q + 1'b1;
                    end else if (tile_q == tiles_q - 1'b1) begin
                        state_d = S_FIN;
                    end else begin
                        tile_d  = tile_q + 1'b1;
                        base_d  = base_q + AW'(kcfg_q);
                        rbase_d = rbase_q + MW'(LANES);
                        k_d     = '0;
                        state_d = S_FETCH;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mcfg_q  <= '0;
            kcfg_q  <= '0;
            tiles_q <= '0;
            tile_q  <= '0;
            k_q     <= '0;
            base_q  <= '0;
            rbase_q <= '0;
            lane_q  <= '0;
            err_q   <= 1'b0;
            waddr_q <= '0;
            iaddr_q <= '0;
            issue_q <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mcfg_q  <= mcfg_d;
            kcfg_q  <= kcfg_d;
            tiles_q <= tiles_d;
            tile_q  <= tile_d;
            k_q     <= k_d;
            base_q  <= base_d;
            rbase_q <= rbase_d;
            lane_q  <= lane_d;
            err_q   <= err_d;
            waddr_q <= weight_bram_addr;
            iaddr_q <= input_bram_addr;
            issue_q <= fetch;
            first_q <= fetch && (k_q == '0);
        end
    end

`ifdef MATVEC_SATURATE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat_flag = sat_q;
`endif

    // Addresses hold their last issued value outside FETCH.
    assign weight_bram_en   = fetch;
    assign input_bram_en    = fetch;
    assign weight_bram_addr = fetch ? (base_q + AW'(k_q)) : waddr_q;
    assign input_bram_addr  = fetch ? AW'(k_q) : iaddr_q;

    logic signed [DATA_W-1:0] x_s;
    assign x_s = signed'(input_bram_dout);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic signed [DATA_W-1:0]   w;
        logic signed [2*DATA_W-1:0] prod;
        logic signed [ACC_W-1:0]    addend, base_v, acc_n, acc_q;

        assign w      = signed'(weight_bram_dout[l*DATA_W +: DATA_W]);
        assign prod   = w * x_s;
        assign addend = ACC_W'(prod);
        assign base_v = first_q ? '0 : acc_q;

`ifdef MATVEC_SATURATE_EN
        logic [ACC_W:0] wide;
        logic           ovf;
        assign wide = {base_v[ACC_W-1], base_v} + {addend[ACC_W-1], addend};
        assign ovf  = wide[ACC_W] != wide[ACC_W-1];
        assign acc_n = !ovf ? signed'(wide[ACC_W-1:0]) :
                       wide[ACC_W] ? signed'({1'b1, {(ACC_W-1){1'b0}}}) :
                                     signed'({1'b0, {(ACC_W-1){1'b1}}});
        assign ovf_vec[l] = ovf;
`else
        assign acc_n      = base_v + addend;
        assign ovf_vec[l] = 1'b0;
`endif

        always_ff @(posedge clk) begin
            if (rst) begin
                acc_q <= '0;
            end else if (issue_q) begin
                acc_q <= acc_n;
            end
        end

        assign acc_flat[l*ACC_W +: ACC_W] = acc_q;
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_FIN);
    assign err       = err_q;
    assign res_valid = out_st;
    assign res_data  = out_st ? acc_flat[lane_q*ACC_W +: ACC_W] : '0;
    assign res_row   = out_st ? RW'(rbase_q + MW'(lane_q)) : '0;

`ifndef MATVEC_SATURATE_EN
    logic unused_ovf;
    assign unused_ovf = ^ovf_vec;
`endif

endmodule

// File: doc/matvec_tile_engine.md
Name: matvec_tile_engine

Overview:
- Self-contained MxK matrix-vector multiply engine built on a parametrised LANES-wide MAC row; computes y = W·x for runtime M ≤ M_MAX and K ≤ K_MAX.
- Owns its scheduler FSM, BRAM address generation, accumulator clear and result streaming. No separate top/tile/valid controllers.
- Sits between the weight/input BRAMs and downstream result consumers.
- Results leave on a valid/ready stream, one row per beat, in ascending row order.

Parameters:
- DATA_W, 16, signed width of weights and inputs.
- ACC_W, 32, signed accumulator/result width; must be ≥ 2*DATA_W.
- LANES, 4, physical MAC lanes, i.e. rows computed per tile.
- M_MAX, 64, maximum runtime row count.
- K_MAX, 64, maximum runtime column count.
- MEM_DEPTH, 256, depth of each BRAM; AW = $clog2(MEM_DEPTH).

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin job; sampled only in IDLE.
- m_rows  in  $clog2(M_MAX+1)  row count M; latched on start.
- k_cols  in  $clog2(K_MAX+1)  column count K; latched on start.
- weight_bram_addr  out  AW  weight read address.
- weight_bram_en  out  1  weight read enable.
- weight_bram_dout  in  LANES*DATA_W  weight word; lane l at [l*DATA_W +: DATA_W]; 1-cycle read latency.
- input_bram_addr  out  AW  input read address.
- input_bram_en  out  1  input read enable.
- input_bram_dout  in  DATA_W  x[k]; 1-cycle read latency.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at job end.
- err  out  1  sticky config error; cleared by the next accepted start.
- res_valid  out  1  result beat valid.
- res_ready  in  1  consumer ready.
- res_data  out  ACC_W  signed y[row].
- res_row  out  $clog2(M_MAX)  row index of res_data.

Behaviour:
- Reset: all outputs 0, FSM→IDLE, accumulators 0, latched config 0.
- Reset mid-job: abandons the job immediately; no further beats, no done pulse.
- FSM states: IDLE, CHECK, FETCH, DRAIN, OUT, FIN.
- IDLE: on start, latch m_rows/k_cols → CHECK. start is ignored in all other states.
- CHECK (1 cycle): the config is invalid if M=0, K=0, M>M_MAX, K>K_MAX, or T*K > MEM_DEPTH, where T = ceil(M/LANES).
  - Invalid: set err → FIN; no BRAM reads, no beats.
  - Valid: tile=0, k=0 → FETCH.
- FETCH (K cycles): en=1 on both BRAMs.
  - weight_bram_addr = tile*K + k; input_bram_addr = k; k increments each cycle.
  - After the k=K-1 issue → DRAIN.
- MAC pipeline: a 1-cycle delayed issue flag qualifies the BRAM data.
  - lane l: acc_l ← (first beat of tile ? 0 : acc_l) + sext(w_l * x).
  - Product is full 2*DATA_W signed, sign-extended to ACC_W.
  - Default arithmetic wraps modulo 2^ACC_W.
- DRAIN (1 cycle): last product accumulates; en=0 → OUT with lane=0.
- OUT: beat for lane l carries row = tile*LANES + l.
  - Lanes with row ≥ M are skipped with no beat and 0 cycles consumed; the partial last tile emits only valid rows.
  - res_valid/res_data/res_row stay stable until res_ready. Handshake completes in the cycle res_valid & res_ready.
  - After the last valid lane: if tile < T-1, tile++, k=0 → FETCH; else → FIN.
  - No compute/output overlap: the next tile's fetch waits for a full drain.
- FIN: done=1 for one cycle, busy=0 next cycle → IDLE.
- Latency: first res_valid is asserted K+3 cycles after the cycle start is sampled (CHECK, K FETCH, DRAIN).
- Cycles per tile with res_ready held high: K + 1 + (valid lanes).
- BRAM enables are low outside FETCH; addresses hold their last value.

Optional Feature:
- Macro: MATVEC_SATURATE_EN.
- Defined: each accumulate saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Adds output sat_flag (1 bit): sticky, set on any clamp, cleared by accepted start, 0 on reset.
- Undefined: wrap-around arithmetic; no sat_flag port.

Test Plan:
- Identity: M=4, K=4, LANES=4, W=I, x={3,-5,7,2}, res_ready=1.
  - Required: 4 beats rows 0..3 = {3,-5,7,2}; first res_valid K+3=7 cycles after start; done pulse once.
- Partial tile: M=6, K=3, all weights=1, x={1,2,3}.
  - Required: 6 beats rows 0..5, each = 6; no row 6/7 beat; weight addresses 0..5 issued; done once.
- Backpressure: M=4, K=2, res_ready toggled 1,0,0,1 pattern.
  - Required: res_data/res_row stable while stalled; all 4 values correct; no duplicated or dropped beats.
- Signed extremes: DATA_W=16, w=-32768, x=-32768, K=2.
  - Without macro: result wraps per ACC_W.
  - ACC_W=32 with MATVEC_SATURATE_EN: result = 2^31-1 and sat_flag=1.
- Bad config: M=0, then K=K_MAX+1, then M=64,K=64,LANES=4 (T*K=1024 > 256).
  - Required: each sets err, done pulses 2 cycles after start, zero BRAM enables, zero beats. A following valid start clears err.
- Reset mid-OUT: assert rst while res_valid=1.
  - Required: next cycle all outputs 0, busy=0. A new start runs a correct full job.
